// File: rtl/nibbler_pkg.sv
// Shared constants and types for the Nibbler 4-bit processor.
// Used by the fetch stage, RAM and the decode stage.
package nibbler_pkg;

    localparam int ADDR_W   = 12;
    localparam int NIBBLE_W = 4;
    localparam int INSTR_W  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_HI = 3'd1,
        REQ_LO = 3'd2,
        CAP_LO = 3'd3,
        VALID  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk_i, rst_i      - clock, asynchronous active-high reset (to RESET_PC)
//   load_i/load_val_i - load a new PC (has priority over inc2_i)
//   inc2_i            - advance PC by one instruction (two nibbles)
//   pc_o, pc_plus1_o  - current PC and PC+1 (both wrap modulo 4096)
module pc_reg
    import nibbler_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc2_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)      pc_d = load_val_i;
        else if (inc2_i) pc_d = pc_q + ADDR_W'(2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_q + ADDR_W'(1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads two nibbles (high first) from RAM and
// presents the assembled 8-bit instruction over a valid/ready handshake.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   run                 - fetch enable, sampled at instruction boundaries
//   address, cs, we     - RAM request (we is always 0)
//   mem_rdata           - RAM read data, one cycle after the request
//   instr, instr_valid  - assembled instruction to decode
//   instr_ready         - decode accepts instr
//   jump_en, jump_addr  - PC redirect applied at the handshake
//   pc                  - address of the next instruction's high nibble
module fetch_unit
    import nibbler_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic [ADDR_W-1:0]   address,
    output logic                cs,
    output logic                we,
    input  logic [NIBBLE_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_addr,
    output logic [ADDR_W-1:0]   pc
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_plus1;
    logic               pc_load, pc_inc2;
    logic               hshk;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (pc_load),
        .load_val_i (jump_addr),
        .inc2_i     (pc_inc2),
        .pc_o       (pc),
        .pc_plus1_o (pc_plus1)
    );

    assign hshk = (state_q == VALID) && instr_ready;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cs          = 1'b0;
        address     = pc;
        instr_valid = 1'b0;
        pc_load     = 1'b0;
        pc_inc2     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = REQ_HI;
            end
            REQ_HI: begin
                cs      = 1'b1;
                state_d = REQ_LO;
            end
            REQ_LO: begin
                // Data for the REQ_HI read arrives this cycle.
                cs                              = 1'b1;
                address                         = pc_plus1;
                instr_d[INSTR_W-1:NIBBLE_W]     = mem_rdata;
                state_d                         = CAP_LO;
            end
            CAP_LO: begin
                instr_d[NIBBLE_W-1:0] = mem_rdata;
                pc_inc2               = 1'b1;
                state_d               = VALID;
            end
            VALID: begin
                instr_valid = 1'b1;
                if (hshk) begin
                    pc_load = jump_en;
                    state_d = run ? REQ_HI : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    assign instr = instr_q;
    assign we    = 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, run, cs, we, instr_valid, instr_ready, jump_en;
    logic [11:0] address, jump_addr, pc;
    logic [3:0]  mem_rdata;
    logic [7:0]  instr;

    logic [3:0]  mem [4096];

    typedef struct {
        logic [7:0]  instr;
        logic [11:0] pc;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(12'h000)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .address     (address),
        .cs          (cs),
        .we          (we),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .pc          (pc)
    );

    // RAM model: samples address/cs on the edge, data visible next cycle.
    always @(posedge clk) if (cs && !we) mem_rdata <= mem[address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] i, input logic [11:0] p);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        sb.push_back(e);
    endtask

    // Handshake monitor: pops the scoreboard on every accepted instruction.
    always @(negedge clk) begin
        chk("we", {31'd0, we}, 32'd0);
        if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty_pop", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hs_instr", {24'd0, instr}, {24'd0, e.instr});
                chk("hs_pc", {20'd0, pc}, {20'd0, e.pc});
            end
        end
    end

    task automatic chk_req(input string tag, input logic c, input logic [11:0] a);
        chk({tag, "_cs"}, {31'd0, cs}, {31'd0, c});
        if (c) chk({tag, "_addr"}, {20'd0, address}, {20'd0, a});
    endtask

    task automatic chk_valid(input string tag, input logic [7:0] i, input logic [11:0] p);
        chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, {24'd0, instr}, {24'd0, i});
        chk({tag, "_pc"}, {20'd0, pc}, {20'd0, p});
        chk({tag, "_cs"}, {31'd0, cs}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'(i * 7 + 3);
        mem[12'h000] = 4'hA; mem[12'h001] = 4'h5;
        mem[12'h002] = 4'h3; mem[12'h003] = 4'hC;
        mem[12'h014] = 4'h7; mem[12'h015] = 4'hE;
        mem[12'hFFF] = 4'h9;

        reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
        jump_en = 1'b0; jump_addr = 12'h000;
        #3;
        chk("rst_cs", {31'd0, cs}, 32'd0);
        chk("rst_vld", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", {20'd0, pc}, 32'h000);
        chk("rst_addr", {20'd0, address}, 32'h000);
        chk("rst_instr", {24'd0, instr}, 32'h00);
        step(); step();
        reset = 1'b0;
        step();
        chk_req("idle", 1'b0, 12'h000);

        // Basic fetch
        run = 1'b1;
        step(); chk_req("b_hi", 1'b1, 12'h000);
        step(); chk_req("b_lo", 1'b1, 12'h001);
        step(); chk_req("b_cap", 1'b0, 12'h000);
        chk("b_cap_vld", {31'd0, instr_valid}, 32'd0);
        step(); chk_valid("b", 8'hA5, 12'h002);

        // Back-pressure for 5 cycles
        for (int k = 0; k < 5; k++) begin
            step(); chk_valid("bp", 8'hA5, 12'h002);
        end

        // Jump at handshake
        push(8'hA5, 12'h002);
        instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 12'h014;
        step(); chk_req("j_hi", 1'b1, 12'h014);
        instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 12'h123;  // ignored
        step(); chk_req("j_lo", 1'b1, 12'h015);
        jump_en = 1'b0;
        step(); chk_req("j_cap", 1'b0, 12'h000);
        step(); chk_valid("j", 8'h7E, 12'h016);

        // Wrap-around
        push(8'h7E, 12'h016);
        instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 12'hFFF;
        step(); chk_req("w_hi", 1'b1, 12'hFFF);
        instr_ready = 1'b0; jump_en = 1'b0;
        step(); chk_req("w_lo", 1'b1, 12'h000);
        step(); chk_req("w_cap", 1'b0, 12'h000);
        step(); chk_valid("w", 8'h9A, 12'h001);

        // Reset in REQ_LO
        push(8'h9A, 12'h001);
        instr_ready = 1'b1;
        step(); chk_req("r_hi", 1'b1, 12'h001);
        instr_ready = 1'b0;
        step(); chk_req("r_lo", 1'b1, 12'h002);
        reset = 1'b1;
        #1;
        chk("r_cs", {31'd0, cs}, 32'd0);
        chk("r_vld", {31'd0, instr_valid}, 32'd0);
        chk("r_pc", {20'd0, pc}, 32'h000);
        chk("r_instr", {24'd0, instr}, 32'h00);
        reset = 1'b0;

        // Restart from RESET_PC; drop run in REQ_HI
        step(); chk_req("s_hi", 1'b1, 12'h000);
        run = 1'b0;
        step(); chk_req("s_lo", 1'b1, 12'h001);
        step(); chk_req("s_cap", 1'b0, 12'h000);
        step(); chk_valid("s", 8'hA5, 12'h002);
        push(8'hA5, 12'h002);
        instr_ready = 1'b1;
        step();
        chk_req("s_idle0", 1'b0, 12'h000);
        chk("s_idle0_vld", {31'd0, instr_valid}, 32'd0);
        chk("s_idle0_addr", {20'd0, address}, 32'h002);
        instr_ready = 1'b0;
        step(); chk_req("s_idle1", 1'b0, 12'h000);
        step(); chk_req("s_idle2", 1'b0, 12'h000);
        chk("s_idle2_pc", {20'd0, pc}, 32'h002);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Nibbler 4-bit processor, directly upstream of the `RAM` block. It holds the 12-bit program counter and drives `address`, `cs` and `we` into `RAM`. Each 8-bit instruction is assembled from two consecutive 4-bit reads, high nibble first. The finished instruction is presented to the decode stage over a valid/ready handshake, and jumps are applied at the handshake.

## Interface
Parameters:
- `RESET_PC`, default 12'h000: program counter value after reset.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `run`, input, 1: start fetching when high; when low, stop at the next instruction boundary.
- `address`, output, 12: RAM address.
- `cs`, output, 1: RAM chip select, active high.
- `we`, output, 1: RAM write enable; tied to 0 because this block only reads.
- `mem_rdata`, input, 4: RAM read data, taken from the `data` bus.
- `instr`, output, 8: assembled instruction, `{hi_nibble, lo_nibble}`.
- `instr_valid`, output, 1: `instr` is valid and is being held.
- `instr_ready`, input, 1: decode stage accepts `instr`.
- `jump_en`, input, 1: load `jump_addr` into the PC at the handshake.
- `jump_addr`, input, 12: jump target.
- `pc`, output, 12: current program counter, which is the address of the next instruction's high nibble.

## Operation
RAM read contract:
- `RAM` samples `address` and `cs` on a rising edge with `we`=0.
- The read data appears on `mem_rdata` during the following cycle.
- `fetch_unit` captures that data on the next rising edge.

State machine (enumerated states):
- IDLE:
  - `cs`=0, `address`=`pc`.
  - Go to REQ_HI when `run`=1.
- REQ_HI:
  - `cs`=1, `address`=`pc`.
  - Always go to REQ_LO.
- REQ_LO:
  - `cs`=1, `address`=`pc`+1, wrapping modulo 4096.
  - Capture `mem_rdata` into `instr[7:4]`.
  - Always go to CAP_LO.
- CAP_LO:
  - `cs`=0.
  - Capture `mem_rdata` into `instr[3:0]`.
  - Set `pc` to `pc`+2, modulo 4096.
  - Always go to VALID.
- VALID:
  - `instr_valid`=1, `cs`=0; `instr` is held stable.
  - On `instr_valid` && `instr_ready`:
    - If `jump_en`=1, `pc` <= `jump_addr`; otherwise `pc` is unchanged.
    - Go to REQ_HI if `run`=1, else IDLE.
  - Without a handshake, stay in VALID.

Outputs `cs`, `address` and `instr_valid` are decoded combinationally from state and `pc`. `instr` and `pc` are registers.

Rules:
- `jump_en` and `jump_addr` are ignored outside an accepted handshake.
- Odd `jump_addr` values are legal; fetch then proceeds from that odd address.
- PC wrap-around:
  - From `pc`=12'hFFE, the reads go to 12'hFFE and 12'hFFF, then `pc` becomes 12'h000.
  - From `pc`=12'hFFF, the reads go to 12'hFFF and 12'h000, then `pc` becomes 12'h001.
- Deasserting `run` in REQ_HI, REQ_LO or CAP_LO does not abort the current fetch. It completes to VALID, and the block goes to IDLE after the handshake.
- `we` is 0 in every state.

## Timing
- Reset, asynchronous and immediate:
  - state = IDLE, `pc` = `RESET_PC`, `instr` = 8'h00.
  - `instr_valid` = 0, `cs` = 0, `we` = 0, `address` = `RESET_PC`.
- Latency:
  - Cycle 0 is the first cycle in REQ_HI.
  - `instr_valid` rises at the start of cycle 3.
- Throughput: 4 cycles per instruction when `instr_ready` is held at 1.
- Reset asserted mid-fetch or in VALID:
  - `cs` and `instr_valid` drop in the same cycle.
  - The partially assembled instruction is discarded.
  - After release, fetch restarts from `RESET_PC` once `run`=1.
- `run` and `reset` are both high: reset wins.

## Structure
- Package `nibbler_pkg` holds:
  - `ADDR_W`=12, `NIBBLE_W`=4, `INSTR_W`=8.
  - The `fetch_state_t` enum: IDLE, REQ_HI, REQ_LO, CAP_LO, VALID.
  - These constants are shared with `RAM` and the decode stage.
- Sub-module `pc_reg`:
  - 12-bit register with asynchronous reset to `RESET_PC`.
  - Controls `load`/`load_val` and `inc2`; `load` has priority.
  - Outputs `pc` and `pc_plus1`.

## Test plan
- **Basic fetch:** RAM[0]=4'hA, RAM[1]=4'h5, `run`=1, `instr_ready`=1.
  - `address` shows 0 then 1 while `cs`=1.
  - `instr`=8'hA5 with `instr_valid` rising 3 cycles after REQ_HI.
  - `pc`=2.
- **Back-pressure:** hold `instr_ready`=0 for 5 cycles while in VALID.
  - `instr` stays 8'hA5, `cs` stays 0, `pc` stays 2.
  - The next fetch starts the cycle after `instr_ready` rises.
- **Jump:** at the handshake, `jump_en`=1 and `jump_addr`=12'h014.
  - The next REQ_HI drives `address`=12'h014, then 12'h015.
  - `pc` becomes 12'h016.
- **Wrap-around:** jump to 12'hFFF.
  - Reads go to 12'hFFF, then 12'h000.
  - `pc` becomes 12'h001.
- **Reset in REQ_LO:** pulse `reset` for 1 ns.
  - `cs`=0, `instr_valid`=0, `pc`=`RESET_PC` immediately.
  - Fetch restarts at address 0.
- **Stop:** drop `run` in REQ_HI.
  - The fetch completes, and after the handshake the block sits in IDLE with `cs`=0.
  - `we` is 0 throughout all scenarios.
